// File: rtl/instr_fetch_queue_pkg.sv
// Shared widths, fetch FSM encodings and opcode field helpers for the
// instruction fetch stage.
package instr_fetch_queue_pkg;

  localparam int IFQ_WORD_W = 16;
  localparam int IFQ_ADDR_W = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  function automatic logic [3:0] opc_major(input logic [IFQ_WORD_W-1:0] w);
    return w[15:12];
  endfunction

  function automatic logic [3:0] opc_minor(input logic [IFQ_WORD_W-1:0] w);
    return w[11:8];
  endfunction

endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Prefetch FIFO holding {pc, word} pairs; a flush empties it in one cycle
// and takes priority over any push or pop in the same cycle.
module fetch_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop, full;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= push_data_i;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Upstream credit accounting must never let a push land on a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && full && !do_pop));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: PC sequencing, credit-limited reads of text memory, epoch
// tagging so stale responses after a redirect are dropped, and halt.
//
// state     | meaning
// ST_IDLE   | one cycle after reset release, no fetch
// ST_RUN    | issuing reads while FIFO credit remains
// ST_HALTED | no issue, FIFO drains, redirects ignored (sticky)
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int WORD_W = IFQ_WORD_W,
  parameter int ADDR_W = IFQ_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              ir_valid,
  output logic [WORD_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              halted
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam int EW = ADDR_W + WORD_W;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W:0]   tag_q, tag_d;
  logic              epoch_q, epoch_d;

  logic              run, flush, deq, issue, push;
  logic [CW-1:0]     count;
  logic [OW-1:0]     occ;
  logic [EW-1:0]     head;
  logic              empty;

  assign run   = (state_q == ST_RUN);
  assign flush = run & redirect_valid;
  assign deq   = ir_valid & ir_ready & ~flush;
  // Occupancy counts the in-flight read so its response always has a slot.
  assign occ   = OW'(count) + OW'(inflight_q) - OW'(deq);
  assign issue = run & ~redirect_valid & ~halt_req & (occ < OW'(DEPTH));
  assign push  = inflight_q & (tag_q[ADDR_W] == epoch_q) & ~flush;

  assign imem_en   = issue;
  assign imem_addr = fetch_pc_q;
  assign ir_valid  = ~empty;
  assign ir        = head[WORD_W-1:0];
  assign ir_pc     = head[EW-1:WORD_W];
  assign halted    = (state_q == ST_HALTED);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_RUN;
      ST_RUN:    if (halt_req) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (flush)      fetch_pc_d = redirect_pc;
    else if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    epoch_d    = epoch_q ^ flush;
    inflight_d = issue;
    tag_d      = issue ? {epoch_q, fetch_pc_q} : tag_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      epoch_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      epoch_q    <= epoch_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i ({tag_q[ADDR_W-1:0], imem_rdata}),
    .pop_i       (deq),
    .head_o      (head),
    .count_o     (count),
    .empty_o     (empty)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: startup latency, backpressure,
// redirects (incl. PC wrap), halt and asynchronous reset mid-stream.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0;
  logic        ir_valid;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic        halted;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.WORD_W(16), .ADDR_W(16), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .ir_valid       (ir_valid),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_ready       (ir_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted)
  );

  function automatic logic [15:0] text_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0001: return 16'h2222;
      16'h0002: return 16'h3333;
      16'h0003: return 16'h4444;
      default:  return a ^ 16'h5A00;
    endcase
  endfunction

  // Synchronous text memory: one cycle read latency.
  always @(posedge clk) if (imem_en) imem_rdata <= text_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Leaves time at posedge+1; callers add #1 before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ends in cycle 0 (IDLE), posedge+2, reset released before the next edge.
  task automatic do_reset(input logic rdy);
    reset          = 1'b0;
    ir_ready       = rdy;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    halt_req       = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic startup(input string p);
    check({p, "_cyc0_en"}, 32'(imem_en), 32'd0);
    tick(); #1;
    check({p, "_cyc1_en"}, 32'(imem_en), 32'd1);
    check({p, "_cyc1_addr"}, 32'(imem_addr), 32'h0);
    tick(); #1;
    check({p, "_cyc2_valid"}, 32'(ir_valid), 32'd0);
    check({p, "_cyc2_addr"}, 32'(imem_addr), 32'h1);
    tick(); #1;
    check({p, "_cyc3_valid"}, 32'(ir_valid), 32'd1);
    check({p, "_cyc3_ir"}, 32'(ir), 32'h1111);
    check({p, "_cyc3_pc"}, 32'(ir_pc), 32'h0);
    for (int i = 1; i < 4; i++) begin
      tick(); #1;
      check({p, "_stream_ir"}, 32'(ir), 32'(text_word(16'(i))));
      check({p, "_stream_pc"}, 32'(ir_pc), 32'(i));
    end
  endtask

  initial begin
    int issues;

    reset          = 1'b0;
    ir_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    halt_req       = 1'b0;
    tick(); #1;
    check("rst_en",     32'(imem_en),   32'd0);
    check("rst_addr",   32'(imem_addr), 32'h0);
    check("rst_valid",  32'(ir_valid),  32'd0);
    check("rst_ir",     32'(ir),        32'h0);
    check("rst_pc",     32'(ir_pc),     32'h0);
    check("rst_halted", 32'(halted),    32'd0);

    // Scenario 1: startup latency and steady stream
    do_reset(1'b1);
    startup("s1");

    // Scenario 2: backpressure limits issue to DEPTH
    do_reset(1'b0);
    issues = 0;
    for (int c = 0; c < 10; c++) begin
      if (imem_en) issues++;
      tick(); #1;
    end
    check("s2_issues", 32'(issues), 32'd4);
    check("s2_en_off", 32'(imem_en), 32'd0);
    check("s2_valid",  32'(ir_valid), 32'd1);
    ir_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("s2_drain_pc", 32'(ir_pc), 32'(i));
      check("s2_drain_ir", 32'(ir), 32'(text_word(16'(i))));
      tick(); #1;
    end

    // Scenario 3: redirect with two queued and one in flight (cycle 4)
    do_reset(1'b0);
    repeat (4) tick();
    #1;
    check("s3_pre_valid", 32'(ir_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    #1;
    check("s3_redir_en", 32'(imem_en), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("s3_r1_valid", 32'(ir_valid), 32'd0);
    check("s3_r1_en",    32'(imem_en), 32'd1);
    check("s3_r1_addr",  32'(imem_addr), 32'h0040);
    tick(); #1;
    tick(); #1;
    check("s3_tgt_valid", 32'(ir_valid), 32'd1);
    check("s3_tgt_pc",    32'(ir_pc), 32'h0040);
    check("s3_tgt_ir",    32'(ir), 32'h5A40);
    ir_ready = 1'b1;
    tick(); #1;
    check("s3_next_pc", 32'(ir_pc), 32'h0041);
    check("s3_next_ir", 32'(ir), 32'h5A41);

    // Scenario 4: redirect to 0xFFFE, PC wraps
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    #1;
    tick(); #1;
    tick(); #1;
    check("s4_pc0", 32'(ir_pc), 32'hFFFE);
    check("s4_ir0", 32'(ir), 32'hA5FE);
    tick(); #1;
    check("s4_pc1", 32'(ir_pc), 32'hFFFF);
    check("s4_ir1", 32'(ir), 32'hA5FF);
    tick(); #1;
    check("s4_pc2", 32'(ir_pc), 32'h0000);
    check("s4_ir2", 32'(ir), 32'h1111);
    tick(); #1;
    check("s4_pc3", 32'(ir_pc), 32'h0001);
    check("s4_ir3", 32'(ir), 32'h2222);

    // Scenario 5: halt with three queued and one in flight (cycle 5)
    do_reset(1'b0);
    repeat (5) tick();
    #1;
    check("s5_pre_pc", 32'(ir_pc), 32'h0);
    halt_req = 1'b1;
    ir_ready = 1'b1;
    #1;
    check("s5_halt_en",  32'(imem_en), 32'd0);
    check("s5_halt_hlt", 32'(halted), 32'd0);
    tick();
    halt_req = 1'b0;
    #1;
    check("s5_halted1", 32'(halted), 32'd1);
    check("s5_pc1",     32'(ir_pc), 32'h1);
    check("s5_en1",     32'(imem_en), 32'd0);
    tick(); #1;
    check("s5_pc2", 32'(ir_pc), 32'h2);
    tick(); #1;
    check("s5_pc3", 32'(ir_pc), 32'h3);
    check("s5_ir3", 32'(ir), 32'h4444);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0080;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("s5_empty",  32'(ir_valid), 32'd0);
    check("s5_en_off", 32'(imem_en), 32'd0);
    tick(); #1;
    check("s5_still_empty", 32'(ir_valid), 32'd0);
    check("s5_still_en",    32'(imem_en), 32'd0);
    check("s5_sticky",      32'(halted), 32'd1);

    // Scenario 6: asynchronous reset mid-stream
    do_reset(1'b1);
    repeat (5) tick();
    #1;
    check("s6_pre_valid", 32'(ir_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("s6_async_valid", 32'(ir_valid), 32'd0);
    check("s6_async_en",    32'(imem_en), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    startup("s6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
